// File: rtl/gate_exerciser_pkg.sv
// rtl/gate_exerciser_pkg.sv - shared types, truth tables and helpers for the gate exerciser
//
// Purpose: state encoding for the exerciser FSM, truth-table constants for the
//          common two-input gate cells, and the expected-bit lookup.
// Ports:   none (package).
package gate_test_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bit k of a truth table is the expected output for input vector k.
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;

    // Tables are zero-extended to 16 bits so one helper serves every N_IN up to 4.
    function automatic logic exp_bit(input logic [15:0] tt, input logic [3:0] vec);
        return tt[vec];
    endfunction

endpackage

// File: rtl/gate_exerciser_if.sv
// rtl/gate_exerciser_if.sv - link between the exerciser and the gate under test
//
// Purpose: carries the applied input vector out to the gate and its output back.
// Signals: dut_in  [N_IN-1:0]  vector driven to the gate (bit 0 = a, bit 1 = b)
//          dut_out            gate output returned to the exerciser
// Modports: master (exerciser side), slave (gate side).
interface gate_exerciser_if #(
    parameter int N_IN = 2
);
    logic [N_IN-1:0] dut_in;
    logic            dut_out;

    modport master (output dut_in, input dut_out);
    modport slave  (input dut_in, output dut_out);
endinterface

// File: rtl/gate_exerciser_timer.sv
// rtl/gate_exerciser_timer.sv - per-vector hold counter
//
// Purpose: counts the cycles a vector has been applied and flags the sample cycle.
// Ports:   clk, rst_n  clock and asynchronous active-low reset
//          clr         forces the count back to zero (wins over en)
//          en          advances the count by one
//          last        high while the count equals HOLD_CYCLES-1
module gate_exerciser_timer #(
    parameter int HOLD_CYCLES = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic last
);
    localparam int CW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == CW'(HOLD_CYCLES - 1));

endmodule

// File: rtl/gate_exerciser.sv
// rtl/gate_exerciser.sv - stimulus/response engine sweeping a small combinational gate
//
// Purpose: applies every input vector to the gate, holds it HOLD_CYCLES cycles,
//          samples the gate output on the last hold cycle and compares it to EXP_TT.
// Ports:   clk, rst_n       clock and asynchronous active-low reset
//          start            pulse, begins a sweep when idle
//          abort            level, cancels an active sweep
//          gif              gate link (dut_in out, dut_out in)
//          busy             high while a sweep is active
//          done             one-cycle pulse at sweep completion
//          pass             last completed sweep had zero mismatches
//          err_count        mismatches in the current or last sweep
//          fail_valid       at least one mismatch recorded
//          first_fail_vec   input vector of the first mismatch
module gate_exerciser
    import gate_test_pkg::*;
#(
    parameter int                   N_IN        = 2,
    parameter int                   HOLD_CYCLES = 5,
    parameter logic [(1<<N_IN)-1:0] EXP_TT      = TT_AND
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    gate_exerciser_if.master  gif,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_count,
    output logic              fail_valid,
    output logic [N_IN-1:0]   first_fail_vec
);

    state_t            state_q;
    logic [N_IN-1:0]   dut_in_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic [N_IN:0]     err_count_q;
    logic [N_IN:0]     err_count_d;
    logic              fail_valid_q;
    logic [N_IN-1:0]   first_fail_vec_q;

    logic              hold_last;
    logic              timer_clr;
    logic              timer_en;
    logic              compare_now;
    logic              mismatch;
    logic              last_vec;

    // The counter only runs in APPLY; it is held at zero elsewhere so every
    // vector, including the first after start, gets the full hold time.
    assign timer_en  = (state_q == APPLY);
    assign timer_clr = (state_q != APPLY) || hold_last || abort;

    gate_exerciser_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (timer_clr),
        .en    (timer_en),
        .last  (hold_last)
    );

    // An abort on the sample cycle discards that compare.
    assign compare_now = (state_q == APPLY) && hold_last && !abort;
    assign mismatch    = compare_now &&
                         (gif.dut_out != exp_bit(16'(EXP_TT), 4'(dut_in_q)));
    assign err_count_d = err_count_q + {{N_IN{1'b0}}, mismatch};
    assign last_vec    = (dut_in_q == {N_IN{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            dut_in_q         <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            err_count_q      <= '0;
            fail_valid_q     <= 1'b0;
            first_fail_vec_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q          <= APPLY;
                        busy_q           <= 1'b1;
                        dut_in_q         <= '0;
                        pass_q           <= 1'b0;
                        err_count_q      <= '0;
                        fail_valid_q     <= 1'b0;
                        first_fail_vec_q <= '0;
                    end
                end
                APPLY: begin
                    if (abort) begin
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                        dut_in_q <= '0;
                        pass_q   <= 1'b0;
                    end else if (hold_last) begin
                        err_count_q <= err_count_d;
                        if (mismatch && !fail_valid_q) begin
                            first_fail_vec_q <= dut_in_q;
                            fail_valid_q     <= 1'b1;
                        end
                        if (last_vec) begin
                            // done/pass are registered here so they are valid
                            // during the single DONE cycle.
                            state_q  <= DONE;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            pass_q   <= (err_count_d == '0);
                            dut_in_q <= '0;
                        end else begin
                            dut_in_q <= dut_in_q + {{(N_IN-1){1'b0}}, 1'b1};
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gif.dut_in     = dut_in_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_count_q;
    assign fail_valid     = fail_valid_q;
    assign first_fail_vec = first_fail_vec_q;

endmodule

// File: tb/tb_gate_exerciser.sv
// tb/tb_gate_exerciser.sv - self-checking bench for gate_exerciser
module tb_gate_exerciser;
    import gate_test_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: two-input gate, default timing, AND expected.
    logic       start0 = 1'b0, abort0 = 1'b0;
    logic       busy0, done0, pass0, fv0;
    logic [2:0] err0;
    logic [1:0] ffv0;
    logic [3:0] gate_tt0 = TT_AND;
    gate_exerciser_if #(.N_IN(2)) if0 ();
    assign if0.dut_out = gate_tt0[if0.dut_in];

    gate_exerciser #(.N_IN(2), .HOLD_CYCLES(5), .EXP_TT(TT_AND)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .gif(if0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .fail_valid(fv0), .first_fail_vec(ffv0)
    );

    // Instance 1: three-input gate, minimum hold, 3-input AND expected.
    logic       start1 = 1'b0, abort1 = 1'b0;
    logic       busy1, done1, pass1, fv1;
    logic [3:0] err1;
    logic [2:0] ffv1;
    logic [7:0] gate_tt1 = 8'h80;
    gate_exerciser_if #(.N_IN(3)) if1 ();
    assign if1.dut_out = gate_tt1[if1.dut_in];

    gate_exerciser #(.N_IN(3), .HOLD_CYCLES(2), .EXP_TT(8'h80)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .gif(if1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_valid(fv1), .first_fail_vec(ffv1)
    );

    int n_chk = 0;
    int n_err = 0;

    function automatic void chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int cur_busy(input int w); return w ? int'(busy1) : int'(busy0); endfunction
    function automatic int cur_done(input int w); return w ? int'(done1) : int'(done0); endfunction
    function automatic int cur_in(input int w);   return w ? int'(if1.dut_in) : int'(if0.dut_in); endfunction
    function automatic int cur_err(input int w);  return w ? int'(err1) : int'(err0); endfunction
    function automatic int cur_fv(input int w);   return w ? int'(fv1) : int'(fv0); endfunction
    function automatic int cur_ffv(input int w);  return w ? int'(ffv1) : int'(ffv0); endfunction
    function automatic int cur_pass(input int w); return w ? int'(pass1) : int'(pass0); endfunction

    function automatic void set_start(input int w, input logic v);
        if (w != 0) start1 = v; else start0 = v;
    endfunction

    // Reference: a sweep compares every vector once, so the outcome is just the
    // set of vectors where the gate's table disagrees with the expected table.
    function automatic void model(input int nvec, input logic [7:0] exp_tt,
                                  input logic [7:0] gate_tt,
                                  output int e_err, output int e_ffv);
        e_err = 0;
        e_ffv = 0;
        for (int v = nvec - 1; v >= 0; v--) begin
            if (gate_tt[v] != exp_tt[v]) begin
                e_err++;
                e_ffv = v;
            end
        end
    endfunction

    task automatic sweep(input int w, input logic [7:0] tt, input int e_err,
                         input int e_ffv, input bit extra, input string name);
        int nvec, hold, busy_cnt, done_at, done_cnt, seq_bad;
        nvec = (w != 0) ? 8 : 4;
        hold = (w != 0) ? 2 : 5;
        if (w != 0) gate_tt1 = tt; else gate_tt0 = tt[3:0];
        set_start(w, 1'b1);
        step();
        set_start(w, 1'b0);
        busy_cnt = 0; done_at = 0; done_cnt = 0; seq_bad = 0;
        for (int c = 1; c <= nvec * hold + 8; c++) begin
            if (cur_busy(w) != 0) begin
                busy_cnt++;
                if (cur_in(w) != (c - 1) / hold) seq_bad++;
            end
            if (cur_done(w) != 0) begin
                done_cnt++;
                done_at = c;
            end
            // Extra starts land mid-sweep and on the DONE cycle; both are ignored.
            if (extra) set_start(w, (c == 3) || (c == 12) || (c == nvec * hold + 1));
            step();
        end
        set_start(w, 1'b0);
        chk({name, " busy_len"}, busy_cnt, nvec * hold);
        chk({name, " done_at"}, done_at, nvec * hold + 1);
        chk({name, " done_cnt"}, done_cnt, 1);
        chk({name, " vec_seq"}, seq_bad, 0);
        chk({name, " err_count"}, cur_err(w), e_err);
        chk({name, " fail_valid"}, cur_fv(w), (e_err != 0) ? 1 : 0);
        chk({name, " first_fail"}, cur_ffv(w), e_ffv);
        chk({name, " pass"}, cur_pass(w), (e_err == 0) ? 1 : 0);
        chk({name, " idle_vec"}, cur_in(w), 0);
    endtask

    task automatic abort_at(input int c_ab, input logic [3:0] tt, input int e_err,
                            input int e_ffv, input string name);
        int done_cnt;
        gate_tt0 = tt;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        for (int c = 1; c <= c_ab; c++) begin
            if (c == c_ab) abort0 = 1'b1;
            step();
        end
        abort0 = 1'b0;
        chk({name, " busy"}, int'(busy0), 0);
        chk({name, " dut_in"}, int'(if0.dut_in), 0);
        chk({name, " err_count"}, int'(err0), e_err);
        chk({name, " fail_valid"}, int'(fv0), (e_err != 0) ? 1 : 0);
        chk({name, " first_fail"}, int'(ffv0), e_ffv);
        chk({name, " pass"}, int'(pass0), 0);
        done_cnt = 0;
        for (int c = 0; c < 25; c++) begin
            if (done0) done_cnt++;
            step();
        end
        chk({name, " no_done"}, done_cnt, 0);
    endtask

    task automatic check_reset0(input string name);
        chk({name, " busy"}, int'(busy0), 0);
        chk({name, " done"}, int'(done0), 0);
        chk({name, " pass"}, int'(pass0), 0);
        chk({name, " err_count"}, int'(err0), 0);
        chk({name, " fail_valid"}, int'(fv0), 0);
        chk({name, " first_fail"}, int'(ffv0), 0);
        chk({name, " dut_in"}, int'(if0.dut_in), 0);
    endtask

    typedef struct {
        logic [3:0] gate_tt;
        int         e_err;
        int         e_ffv;
        string      name;
    } vec_t;

    initial begin
        vec_t tbl[6];
        int   e_err, e_ffv;
        logic [7:0] rtt;

        tbl[0] = '{TT_AND,  0, 0, "and_gate"};
        tbl[1] = '{TT_OR,   2, 1, "or_gate"};
        tbl[2] = '{TT_XOR,  3, 1, "xor_gate"};
        tbl[3] = '{TT_NAND, 4, 0, "nand_gate"};
        tbl[4] = '{4'b0000, 1, 3, "stuck0_gate"};
        tbl[5] = '{4'b1010, 1, 1, "buf_a_gate"};

        #2;
        check_reset0("in_reset");
        step();
        rst_n = 1'b1;
        step();
        check_reset0("after_reset");
        chk("after_reset u1 busy", int'(busy1), 0);

        for (int i = 0; i < 6; i++) begin
            sweep(0, {4'b0, tbl[i].gate_tt}, tbl[i].e_err, tbl[i].e_ffv, 1'b0, tbl[i].name);
        end

        sweep(0, {4'b0, TT_AND}, 0, 0, 1'b1, "start_in_busy");

        abort_at(8, TT_AND, 0, 0, "abort_c8");
        sweep(0, {4'b0, TT_AND}, 0, 0, 1'b0, "after_abort");
        abort_at(10, TT_OR, 0, 0, "abort_on_compare");
        abort_at(15, TT_OR, 1, 1, "abort_c15");

        gate_tt0 = TT_AND;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        for (int c = 1; c < 11; c++) step();
        rst_n = 1'b0;
        #1;
        check_reset0("mid_reset");
        step();
        rst_n = 1'b1;
        step();
        sweep(0, {4'b0, TT_AND}, 0, 0, 1'b0, "after_mid_reset");

        sweep(1, 8'h80, 0, 0, 1'b0, "and3");
        sweep(1, 8'hFF, 7, 0, 1'b0, "and3_stuck1");
        sweep(1, 8'h80, 0, 0, 1'b1, "and3_extra_start");

        for (int i = 0; i < 12; i++) begin
            rtt = 8'($urandom);
            model(4, {4'b0, TT_AND}, rtt, e_err, e_ffv);
            sweep(0, {4'b0, rtt[3:0]}, e_err, e_ffv, 1'b0, $sformatf("rand2_%0d", i));
            rtt = 8'($urandom);
            model(8, 8'h80, rtt, e_err, e_ffv);
            sweep(1, rtt, e_err, e_ffv, 1'b0, $sformatf("rand3_%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
